// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: stall/flush/bubble sequencer for the 5-stage RV32I pipeline
module hazard_stall_ctrl #(
  parameter int MEM_TIMEOUT  = 256,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       id_valid,
  input  logic [6:0] id_opcode,
  input  logic [2:0] id_optype,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] id_rd,
  input  logic       ex_redirect,
  input  logic       mem_req,
  input  logic       mem_ack,
  output logic       stall_if,
  output logic       stall_id,
  output logic       stall_ex,
  output logic       stall_mem,
  output logic       flush_id,
  output logic       bubble_ex,
  output logic       mem_timeout,
  output logic       busy
);
  localparam int WW = $clog2(MEM_TIMEOUT);
  localparam int CW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_SYS  = 7'b1110011;
  typedef enum logic [1:0] {RUN, MEMW, DRAIN} state_t;
  state_t state, state_n;
  logic [WW-1:0] wait_cnt, wait_cnt_n;
  logic [CW-1:0] drain_cnt, drain_cnt_n;
  logic drain_pend, drain_pend_n, to_hold, to_hold_n;
  logic ex_v, ex_ld;
  logic [4:0] ex_rd;
  logic wait_c, tmo, drain_act, drain_stall, sys, use1, use2, lu;
  logic s_if, s_ex, fl, bub;
  // to_hold masks a still-asserted mem_req after a timeout so the trap unit can take over
  always_comb begin
    wait_c = mem_req & ~mem_ack & ~to_hold;
    tmo = wait_c & (wait_cnt == WW'(MEM_TIMEOUT - 1));
    drain_act = (state == DRAIN) | ((state == MEMW) & drain_pend);
    sys = id_valid & (id_opcode == OP_SYS);
    drain_stall = drain_act ? (drain_cnt != '0) : sys;
    use1 = (id_optype != 3'd4) & (id_optype != 3'd5);
    use2 = (id_optype == 3'd0) | (id_optype == 3'd2) | (id_optype == 3'd3);
    lu = id_valid & ex_v & ex_ld & (ex_rd != '0) &
         ((use1 & (ex_rd == id_rs1)) | (use2 & (ex_rd == id_rs2)));
    s_ex = wait_c;
    fl = ~wait_c & ex_redirect;
    s_if = wait_c | (~ex_redirect & (drain_stall | lu));
    bub = fl | (~wait_c & ~ex_redirect & (drain_stall | lu));
  end
  always_comb begin
    state_n = RUN;
    drain_cnt_n = drain_cnt;
    drain_pend_n = 1'b0;
    wait_cnt_n = '0;
    to_hold_n = to_hold & mem_req & ~mem_ack;
    if (tmo) begin
      to_hold_n = 1'b1;
    end else if (wait_c) begin
      state_n = MEMW;
      drain_pend_n = drain_act;
      wait_cnt_n = wait_cnt + WW'(1);
    end else if (~ex_redirect & drain_stall) begin
      state_n = DRAIN;
      drain_cnt_n = drain_act ? drain_cnt - CW'(1) : CW'(DRAIN_CYCLES - 1);
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= RUN;
      wait_cnt <= '0;
      drain_cnt <= '0;
      drain_pend <= 1'b0;
      to_hold <= 1'b0;
      ex_v <= 1'b0;
      ex_ld <= 1'b0;
      ex_rd <= '0;
    end else begin
      state <= state_n;
      wait_cnt <= wait_cnt_n;
      drain_cnt <= drain_cnt_n;
      drain_pend <= drain_pend_n;
      to_hold <= to_hold_n;
      if (!s_ex) begin
        ex_v <= id_valid & ~bub & ~fl & (id_rd != '0);
        ex_ld <= id_opcode == OP_LOAD;
        ex_rd <= id_rd;
      end
    end
  end
  assign stall_if    = rstn & s_if;
  assign stall_id    = rstn & s_if;
  assign stall_ex    = rstn & s_ex;
  assign stall_mem   = rstn & s_ex;
  assign flush_id    = rstn & fl;
  assign bubble_ex   = rstn & bub;
  assign mem_timeout = rstn & tmo;
  assign busy        = rstn & (state != RUN);
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: scoreboard bench; outputs packed {sif,sid,sex,smem,flush,bubble,tmo,busy}
module tb_hazard_stall_ctrl;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] OP = 7'b0110011;
  localparam logic [6:0] SY = 7'b1110011;
  logic clk = 1'b0, rstn;
  logic id_valid, ex_redirect, mem_req, mem_ack;
  logic [6:0] id_opcode;
  logic [2:0] id_optype;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic stall_if, stall_id, stall_ex, stall_mem, flush_id, bubble_ex, mem_timeout, busy;
  logic [7:0] outs;
  int checks = 0, failures = 0;
  typedef struct {string tag; logic [7:0] exp;} exp_t;
  exp_t q[$];
  hazard_stall_ctrl #(.MEM_TIMEOUT(8), .DRAIN_CYCLES(2)) dut (
    .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_opcode(id_opcode), .id_optype(id_optype),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ack(mem_ack), .stall_if(stall_if), .stall_id(stall_id),
    .stall_ex(stall_ex), .stall_mem(stall_mem), .flush_id(flush_id), .bubble_ex(bubble_ex),
    .mem_timeout(mem_timeout), .busy(busy));
  assign outs = {stall_if, stall_id, stall_ex, stall_mem, flush_id, bubble_ex, mem_timeout, busy};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask
  task automatic drv(input string tag, input logic v, input logic [6:0] op, input logic [2:0] ty,
                     input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                     input logic redir, input logic req, input logic ack, input logic [7:0] exp);
    exp_t e;
    @(posedge clk);
    #1;
    id_valid = v; id_opcode = op; id_optype = ty; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    ex_redirect = redir; mem_req = req; mem_ack = ack;
    e.tag = tag; e.exp = exp;
    q.push_back(e);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk(e.tag, outs, e.exp);
    end
  end
  initial begin
    rstn = 1'b0;
    id_valid = 1'b1; id_opcode = LD; id_optype = 3'd1; id_rs1 = 5'd5; id_rs2 = 5'd0; id_rd = 5'd5;
    ex_redirect = 1'b1; mem_req = 1'b1; mem_ack = 1'b0;
    #3 chk("reset_masked", outs, 8'h00);
    @(negedge clk);
    id_valid = 1'b0; ex_redirect = 1'b0; mem_req = 1'b0;
    rstn = 1'b1;
    drv("lu_lw",     1, LD, 1, 2, 0, 5, 0, 0, 0, 8'h00);
    drv("lu_hit1",   1, OP, 0, 5, 1, 6, 0, 0, 0, 8'hC4);
    drv("lu_rel1",   1, OP, 0, 5, 1, 6, 0, 0, 0, 8'h00);
    drv("nh_lw",     1, LD, 1, 2, 0, 5, 0, 0, 0, 8'h00);
    drv("nh_add",    1, OP, 0, 7, 1, 6, 0, 0, 0, 8'h00);
    drv("lu_lw2",    1, LD, 1, 2, 0, 5, 0, 0, 0, 8'h00);
    drv("lu_hit2",   1, OP, 0, 1, 5, 6, 0, 0, 0, 8'hC4);
    drv("lu_rel2",   1, OP, 0, 1, 5, 6, 0, 0, 0, 8'h00);
    drv("x0_lw",     1, LD, 1, 2, 0, 0, 0, 0, 0, 8'h00);
    drv("x0_add",    1, OP, 0, 0, 1, 6, 0, 0, 0, 8'h00);
    drv("b2b_lw1",   1, LD, 1, 2, 0, 5, 0, 0, 0, 8'h00);
    drv("b2b_lw2",   1, LD, 1, 5, 0, 6, 0, 0, 0, 8'hC4);
    drv("b2b_lw2h",  1, LD, 1, 5, 0, 6, 0, 0, 0, 8'h00);
    drv("b2b_add",   1, OP, 0, 6, 1, 7, 0, 0, 0, 8'hC4);
    drv("b2b_addh",  1, OP, 0, 6, 1, 7, 0, 0, 0, 8'h00);
    drv("mw1",       0, 0, 0, 0, 0, 0, 0, 1, 0, 8'hF0);
    drv("mw2",       0, 0, 0, 0, 0, 0, 0, 1, 0, 8'hF1);
    drv("mw3",       0, 0, 0, 0, 0, 0, 0, 1, 0, 8'hF1);
    drv("mw_ack",    0, 0, 0, 0, 0, 0, 0, 1, 1, 8'h01);
    drv("mw_done",   0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    drv("rd_lw",     1, LD, 1, 2, 0, 5, 0, 0, 0, 8'h00);
    drv("rd_flush",  1, OP, 0, 5, 1, 6, 1, 0, 0, 8'h0C);
    drv("rd_next",   1, OP, 0, 5, 1, 6, 0, 0, 0, 8'h00);
    drv("dr_wait",   0, 0, 0, 0, 0, 0, 1, 1, 0, 8'hF0);
    drv("dr_ack",    0, 0, 0, 0, 0, 0, 1, 1, 1, 8'h0D);
    drv("dr_done",   0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    drv("sys_d1",    1, SY, 1, 1, 0, 2, 0, 0, 0, 8'hC4);
    drv("sys_d2",    1, SY, 1, 1, 0, 2, 0, 0, 0, 8'hC5);
    drv("sys_issue", 1, SY, 1, 1, 0, 2, 0, 0, 0, 8'h01);
    drv("sys_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    drv("sysc_d1",   1, SY, 1, 1, 0, 2, 0, 0, 0, 8'hC4);
    drv("sysc_redir",1, SY, 1, 1, 0, 2, 1, 0, 0, 8'h0D);
    drv("sysc_after",0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    drv("sysm_d1",   1, SY, 1, 1, 0, 2, 0, 0, 0, 8'hC4);
    drv("sysm_wait", 1, SY, 1, 1, 0, 2, 0, 1, 0, 8'hF1);
    drv("sysm_ack",  1, SY, 1, 1, 0, 2, 0, 1, 1, 8'hC5);
    drv("sysm_issue",1, SY, 1, 1, 0, 2, 0, 0, 0, 8'h01);
    drv("sysm_after",0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    drv("to_w1",     0, 0, 0, 0, 0, 0, 0, 1, 0, 8'hF0);
    for (int i = 2; i <= 7; i++) drv($sformatf("to_w%0d", i), 0, 0, 0, 0, 0, 0, 0, 1, 0, 8'hF1);
    drv("to_pulse",  0, 0, 0, 0, 0, 0, 0, 1, 0, 8'hF3);
    drv("to_rel",    0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h00);
    drv("to_hold",   0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h00);
    drv("to_drop",   0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    drv("to_again",  0, 0, 0, 0, 0, 0, 0, 1, 0, 8'hF0);
    drv("to_ack",    0, 0, 0, 0, 0, 0, 0, 1, 1, 8'h01);
    drv("rs_w",      0, 0, 0, 0, 0, 0, 0, 1, 0, 8'hF0);
    @(posedge clk);
    #2 chk("rs_memw", outs, 8'hF1);
    rstn = 1'b0;
    #1 chk("rs_async", outs, 8'h00);
    @(posedge clk);
    #1 mem_req = 1'b0;
    #2 rstn = 1'b1;
    #1 chk("rs_post", outs, 8'h00);
    drv("rs_run",    0, 0, 0, 0, 0, 0, 0, 1, 0, 8'hF0);
    drv("rs_ack",    0, 0, 0, 0, 0, 0, 0, 1, 1, 8'h01);
    drv("end",       0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    @(negedge clk);
    #1 chk("queue_empty", 8'(q.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
